// File: rtl/mult_div_pkg.sv
// Shared definitions for the multiply/divide unit: default operand widths and the
// IDLE/CALC/DONE control-state encoding used by both the multiplier and the divider.
package mult_div_pkg;

  localparam int MULTIPLICAND_LENGTH_DEF = 6;
  localparam int MULTIPLIER_LENGTH_DEF   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_datapath.sv
// Shift-add datapath: the multiplicand moves left and the multiplier moves right each
// step, so the bit in mplier_r[0] always lines up with the correctly weighted addend.
module shift_add_datapath
  import mult_div_pkg::*;
#(
  parameter int A_W = MULTIPLICAND_LENGTH_DEF,
  parameter int B_W = MULTIPLIER_LENGTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [A_W-1:0]     oper_a,
  input  logic [B_W-1:0]     oper_b,
  output logic [A_W+B_W-1:0] acc_next
);

  localparam int P_W = A_W + B_W;

  logic [P_W-1:0] mcand_r;
  logic [B_W-1:0] mplier_r;
  logic [P_W-1:0] acc_r;
  logic [P_W-1:0] addend_s;
  logic [P_W-1:0] acc_next_s;

  // Partial product selection and full-width accumulate
  always_comb begin
    addend_s   = {P_W{1'b0}};
    acc_next_s = {P_W{1'b0}};
    if (mplier_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {P_W{1'b0}};
    end
    acc_next_s = acc_r + addend_s;
  end

  // Operand capture on load, one shift-add per step, hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_r  <= {P_W{1'b0}};
      mplier_r <= {B_W{1'b0}};
      acc_r    <= {P_W{1'b0}};
    end else if (load) begin
      mcand_r  <= P_W'(oper_a);
      mplier_r <= oper_b;
      acc_r    <= {P_W{1'b0}};
    end else if (step) begin
      mcand_r  <= mcand_r << 1'b1;
      mplier_r <= mplier_r >> 1'b1;
      acc_r    <= acc_next_s;
    end else begin
      mcand_r  <= mcand_r;
      mplier_r <= mplier_r;
      acc_r    <= acc_r;
    end
  end

  assign acc_next = acc_next_s;

endmodule

// File: rtl/sequential_multiplier.sv
// Unsigned sequential multiplier: one multiplier bit per CALC cycle, fixed latency,
// registered Busy/Done/Product outputs.
module sequential_multiplier
  import mult_div_pkg::*;
#(
  parameter int MULTIPLICAND_LENGTH = MULTIPLICAND_LENGTH_DEF,
  parameter int MULTIPLIER_LENGTH   = MULTIPLIER_LENGTH_DEF
) (
  input  logic                                         CLK,
  input  logic                                         RST,
  input  logic                                         Start,
  input  logic [MULTIPLICAND_LENGTH-1:0]               OperA,
  input  logic [MULTIPLIER_LENGTH-1:0]                 OperB,
  output logic                                         Busy,
  output logic                                         Done,
  output logic [MULTIPLICAND_LENGTH+MULTIPLIER_LENGTH-1:0] Product
);

  localparam int P_W   = MULTIPLICAND_LENGTH + MULTIPLIER_LENGTH;
  localparam int CNT_W = $clog2(MULTIPLIER_LENGTH + 1);

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] count_r;
  logic             load_s;
  logic             step_s;
  logic             busy_r;
  logic             done_r;
  logic [P_W-1:0]   product_r;
  logic [P_W-1:0]   acc_next_s;

  shift_add_datapath #(
    .A_W (MULTIPLICAND_LENGTH),
    .B_W (MULTIPLIER_LENGTH)
  ) u_datapath (
    .clk      (CLK),
    .rst      (RST),
    .load     (load_s),
    .step     (step_s),
    .oper_a   (OperA),
    .oper_b   (OperB),
    .acc_next (acc_next_s)
  );

  // Next-state and datapath strobes
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (Start) begin
          state_s = CALC;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        step_s = 1'b1;
        if (count_r == CNT_W'(1)) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, counter and registered outputs; Product is taken from the final sum
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= IDLE;
      count_r   <= {CNT_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= {P_W{1'b0}};
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
      if (load_s) begin
        count_r <= CNT_W'(MULTIPLIER_LENGTH);
      end else if (step_s) begin
        count_r <= count_r - 1'b1;
      end else begin
        count_r <= count_r;
      end
      if (step_s && (state_s == DONE)) begin
        product_r <= acc_next_s;
      end else begin
        product_r <= product_r;
      end
    end
  end

  assign Busy    = busy_r;
  assign Done    = done_r;
  assign Product = product_r;

endmodule

// File: tb/tb_sequential_multiplier.sv
// Self-checking bench for sequential_multiplier: table vectors, random operands against
// a plain a*b model, and hand sequences for reset abort and continuous Start.
module tb_sequential_multiplier;

  localparam int A_W = 6;
  localparam int B_W = 3;
  localparam int P_W = A_W + B_W;
  localparam int LAT = B_W + 1;

  logic           CLK;
  logic           RST;
  logic           Start;
  logic [A_W-1:0] OperA;
  logic [B_W-1:0] OperB;
  logic           Busy;
  logic           Done;
  logic [P_W-1:0] Product;

  int checks;
  int errors;

  typedef struct {
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [P_W-1:0] exp_p;
  } vec_t;

  vec_t vecs [8];

  sequential_multiplier #(
    .MULTIPLICAND_LENGTH (A_W),
    .MULTIPLIER_LENGTH   (B_W)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .Start   (Start),
    .OperA   (OperA),
    .OperB   (OperB),
    .Busy    (Busy),
    .Done    (Done),
    .Product (Product)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  // One operation; operands and Start are scrambled while busy to prove they are ignored.
  task automatic run_op(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                        input logic [P_W-1:0] exp_p, input string nm);
    int lat;
    int busy_cnt;
    @(negedge CLK);
    OperA = a;
    OperB = b;
    Start = 1'b1;
    @(negedge CLK);
    lat      = 1;
    busy_cnt = 0;
    while (!Done && lat < 12) begin
      if (Busy) busy_cnt++;
      Start = 1'($urandom_range(0, 1));
      OperA = A_W'($urandom);
      OperB = B_W'($urandom);
      @(negedge CLK);
      lat++;
    end
    Start = 1'b0;
    if (Busy) busy_cnt++;
    check({nm, "_latency"}, lat, LAT);
    check({nm, "_product"}, Product, exp_p);
    check({nm, "_busycycles"}, busy_cnt, LAT);
    @(negedge CLK);
    check({nm, "_done_onecycle"}, Done, 1'b0);
    check({nm, "_idle_busy"}, Busy, 1'b0);
    check({nm, "_hold"}, Product, exp_p);
  endtask

  initial begin
    int done_pos [$];
    logic [A_W-1:0] ra;
    logic [B_W-1:0] rb;
    int done_seen;

    checks = 0;
    errors = 0;
    vecs[0] = '{a: 6'd14, b: 3'd3, exp_p: 9'd42};
    vecs[1] = '{a: 6'd63, b: 3'd7, exp_p: 9'd441};
    vecs[2] = '{a: 6'd0,  b: 3'd5, exp_p: 9'd0};
    vecs[3] = '{a: 6'd37, b: 3'd0, exp_p: 9'd0};
    vecs[4] = '{a: 6'd5,  b: 3'd6, exp_p: 9'd30};
    vecs[5] = '{a: 6'd1,  b: 3'd1, exp_p: 9'd1};
    vecs[6] = '{a: 6'd63, b: 3'd1, exp_p: 9'd63};
    vecs[7] = '{a: 6'd1,  b: 3'd4, exp_p: 9'd4};

    RST   = 1'b1;
    Start = 1'b0;
    OperA = '0;
    OperB = '0;
    #1;
    check("reset_busy", Busy, 1'b0);
    check("reset_done", Done, 1'b0);
    check("reset_product", Product, 9'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].exp_p, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      ra = A_W'($urandom);
      rb = B_W'($urandom);
      run_op(ra, rb, P_W'(ra * rb), $sformatf("rand%0d", i));
    end

    // Abort in the second CALC cycle; reset must act without a clock edge.
    @(negedge CLK);
    OperA = 6'd37;
    OperB = 3'd5;
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("abort_busy", Busy, 1'b0);
    check("abort_done", Done, 1'b0);
    check("abort_product", Product, 9'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge CLK);
      if (Done) done_seen++;
    end
    RST = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      if (Done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    check("abort_product_after", Product, 9'd0);
    run_op(6'd5, 3'd6, 9'd30, "after_reset");

    // Start held high: a result every LAT+1 cycles.
    @(negedge CLK);
    OperA = 6'd10;
    OperB = 3'd7;
    Start = 1'b1;
    for (int n = 1; n <= 15; n++) begin
      @(negedge CLK);
      if (Done) begin
        done_pos.push_back(n);
        check("held_product", Product, 9'd70);
      end
      if (n == 15) Start = 1'b0;
    end
    check("held_done_count", done_pos.size(), 3);
    for (int i = 0; i < done_pos.size(); i++) begin
      check($sformatf("held_done_pos%0d", i), done_pos[i], LAT + i * (LAT + 1));
    end
    repeat (6) @(negedge CLK);
    check("final_idle", Busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequential_multiplier.md
SEQUENTIAL_MULTIPLIER -- requirements
Module: sequential_multiplier

Interface
REQ-001 The block SHALL take parameter MULTIPLICAND_LENGTH, default 6, as the width of the multiplicand.
REQ-002 The block SHALL take parameter MULTIPLIER_LENGTH, default 3, as the width of the multiplier and the number of iteration cycles.
REQ-003 The block SHALL have port CLK, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit, the reset; reset is asynchronous and active-high.
REQ-005 The block SHALL have port Start, input, 1 bit, the operation request, sampled only in IDLE.
REQ-006 The block SHALL have port OperA, input, MULTIPLICAND_LENGTH bits, the unsigned multiplicand.
REQ-007 The block SHALL have port OperB, input, MULTIPLIER_LENGTH bits, the unsigned multiplier.
REQ-008 The block SHALL have port Busy, output, 1 bit, high while an operation is in progress.
REQ-009 The block SHALL have port Done, output, 1 bit, a one-cycle pulse marking Product valid.
REQ-010 The block SHALL have port Product, output, MULTIPLICAND_LENGTH+MULTIPLIER_LENGTH bits, the registered unsigned product.

Function
REQ-011 The block SHALL implement a three-state FSM with states IDLE, CALC and DONE.
REQ-012 In IDLE, Start=1 at a rising edge SHALL capture OperA and OperB, clear the accumulator, load the iteration counter with MULTIPLIER_LENGTH, and move to CALC.
REQ-013 In IDLE, Start=0 SHALL keep the FSM in IDLE and leave Product unchanged.
REQ-014 Each CALC cycle SHALL add the multiplicand shifted left by the current bit index to the accumulator if the multiplier bit is 1, processing bits LSB first, then decrement the counter.
REQ-015 CALC SHALL last exactly MULTIPLIER_LENGTH cycles regardless of operand values; no zero-skipping.
REQ-016 After the last CALC cycle the FSM SHALL enter DONE, load Product from the accumulator, and assert Done for exactly one cycle.
REQ-017 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-018 Latency SHALL be MULTIPLIER_LENGTH+1 cycles from the edge sampling Start to the first cycle with Done=1 (default 4).
REQ-019 Busy SHALL be 1 in CALC and DONE and 0 in IDLE.
REQ-020 Start SHALL be ignored in CALC and DONE; the operands of an operation in flight SHALL NOT change.
REQ-021 Operand changes while Busy=1 SHALL NOT affect the result.
REQ-022 Product SHALL hold its value from DONE until the next DONE.
REQ-023 The accumulator SHALL be full width; the maximum product (2^6-1)*(2^3-1)=441 SHALL be represented without overflow.
REQ-024 Start held high continuously SHALL start a new operation on the first IDLE edge after DONE, which gives back-to-back throughput of one result per MULTIPLIER_LENGTH+2 cycles.

Reset
REQ-025 RST=1 SHALL force IDLE immediately, without waiting for CLK, and set Busy=0, Done=0, Product=0, accumulator=0 and counter=0.
REQ-026 RST asserted mid-operation SHALL abort the operation with no Done pulse; Product SHALL read 0 afterwards.
REQ-027 After RST deasserts, the first Start sampled in IDLE SHALL begin a normal operation.

Structure
REQ-028 Width constants and FSM state encodings (IDLE, CALC, DONE) SHALL be defined in the shared package mult_div_pkg, which is reused by the divider side.
REQ-029 The add/shift datapath SHALL be one sub-module, shift_add_datapath, and the FSM and counter SHALL stay in the top module.

Verification
REQ-030 Scenario: OperA=14, OperB=3, Start pulse -> Done at cycle 4, Product=42 (round trip with divider 42/3=14).
REQ-031 Scenario: OperA=63, OperB=7 -> Product=441, Busy high for 4 cycles.
REQ-032 Scenario: OperA=0, OperB=5 and OperA=37, OperB=0 -> Product=0 after the full 4-cycle latency each.
REQ-033 Scenario: Start pulsed and OperA/OperB changed during CALC -> exactly one Done, result equals the originally captured operands.
REQ-034 Scenario: RST asserted in the 2nd CALC cycle -> immediate IDLE, Busy=0, Product=0, no Done; next Start with 5*6 -> Product=30.
REQ-035 Scenario: Start held high with 10*7 -> Done pulses every 5 cycles, Product=70 each time.
